// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keypad-to-ALU input sequencer for the BCD calculator.
// Collects two BCD operands digit by digit, captures the operator, runs the
// ALU through a start/done handshake, supports operator chaining and
// repeat-equals, and holds the result for display. Includes clear handling
// and an ALU error/timeout state.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   is_num/num_val digit key pulse and digit value (values > 9 ignored)
//   is_op/op_val   operator key pulse and operator code
//   is_eq          equals key pulse
//   is_clr         clear key pulse (highest priority, any state)
//   alu_result     BCD result from ALU
//   alu_done       ALU result valid
//   alu_err        ALU error flag, qualified by alu_done
//   num1_bcd       first operand / accumulator
//   num2_bcd       second operand
//   operation      operator presented to the ALU
//   alu_start      one-cycle ALU request (first CALC cycle)
//   result_valid   high while showing a result
//   error          high while in the error state
//   curr_state     state code for debug
module calc_seq_ctrl #(
    parameter int DIGITS  = 4,
    parameter int OP_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_num,
    input  logic                  is_op,
    input  logic                  is_eq,
    input  logic                  is_clr,
    input  logic [3:0]            num_val,
    input  logic [OP_W-1:0]       op_val,
    input  logic [4*DIGITS-1:0]   alu_result,
    input  logic                  alu_done,
    input  logic                  alu_err,
    output logic [4*DIGITS-1:0]   num1_bcd,
    output logic [4*DIGITS-1:0]   num2_bcd,
    output logic [OP_W-1:0]       operation,
    output logic                  alu_start,
    output logic                  result_valid,
    output logic                  error,
    output logic [2:0]            curr_state
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_N1   = 3'd0,
        S_OP   = 3'd1,
        S_N2   = 3'd2,
        S_CALC = 3'd3,
        S_SHOW = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t          r_state,   w_state_nxt;
    logic [W-1:0]    r_num1,    w_num1_nxt;
    logic [W-1:0]    r_num2,    w_num2_nxt;
    logic [CW-1:0]   r_cnt1,    w_cnt1_nxt;
    logic [CW-1:0]   r_cnt2,    w_cnt2_nxt;
    logic [OP_W-1:0] r_op,      w_op_nxt;
    logic [OP_W-1:0] r_pend_op, w_pend_op_nxt;
    logic            r_pend_eq, w_pend_eq_nxt;
    logic [TW-1:0]   r_tcnt,    w_tcnt_nxt;

    // Out-of-range digit codes are treated as if no key was pressed.
    logic w_num;
    assign w_num = is_num && (num_val <= 4'd9);

    // Shift a digit into an operand; saturates at DIGITS, and a leading zero
    // neither changes the register nor advances the counter.
    function automatic logic [CW+W-1:0] enter_digit(
        input logic [W-1:0]  r,
        input logic [CW-1:0] c,
        input logic [3:0]    d
    );
        logic [CW+W-1:0] res;
        res = {c, r};
        if ((c != CW'(DIGITS)) && !((d == 4'd0) && (r == '0)))
            res = {c + CW'(1), (r << 4) | W'(d)};
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_N1;
            r_num1    <= '0;
            r_num2    <= '0;
            r_cnt1    <= '0;
            r_cnt2    <= '0;
            r_op      <= '0;
            r_pend_op <= '0;
            r_pend_eq <= 1'b0;
            r_tcnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_num1    <= w_num1_nxt;
            r_num2    <= w_num2_nxt;
            r_cnt1    <= w_cnt1_nxt;
            r_cnt2    <= w_cnt2_nxt;
            r_op      <= w_op_nxt;
            r_pend_op <= w_pend_op_nxt;
            r_pend_eq <= w_pend_eq_nxt;
            r_tcnt    <= w_tcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_num1_nxt    = r_num1;
        w_num2_nxt    = r_num2;
        w_cnt1_nxt    = r_cnt1;
        w_cnt2_nxt    = r_cnt2;
        w_op_nxt      = r_op;
        w_pend_op_nxt = r_pend_op;
        w_pend_eq_nxt = r_pend_eq;
        // Timeout counter only survives while CALC keeps waiting.
        w_tcnt_nxt    = '0;

        if (is_clr) begin
            w_state_nxt   = S_N1;
            w_num1_nxt    = '0;
            w_num2_nxt    = '0;
            w_cnt1_nxt    = '0;
            w_cnt2_nxt    = '0;
            w_op_nxt      = '0;
            w_pend_op_nxt = '0;
            w_pend_eq_nxt = 1'b0;
        end else begin
            // Only the highest-priority pulse (eq > op > num) is acted on.
            case (r_state)
                S_N1: begin
                    if (is_eq) begin
                        w_state_nxt = S_N1;
                    end else if (is_op) begin
                        w_op_nxt    = op_val;
                        w_state_nxt = S_OP;
                    end else if (w_num) begin
                        {w_cnt1_nxt, w_num1_nxt} = enter_digit(r_num1, r_cnt1, num_val);
                    end
                end
                S_OP: begin
                    if (is_eq) begin
                        w_state_nxt = S_OP;
                    end else if (is_op) begin
                        w_op_nxt = op_val;
                    end else if (w_num) begin
                        w_num2_nxt  = W'(num_val);
                        w_cnt2_nxt  = (num_val == 4'd0) ? '0 : CW'(1);
                        w_state_nxt = S_N2;
                    end
                end
                S_N2: begin
                    if (is_eq) begin
                        w_pend_eq_nxt = 1'b1;
                        w_state_nxt   = S_CALC;
                    end else if (is_op) begin
                        w_pend_op_nxt = op_val;
                        w_pend_eq_nxt = 1'b0;
                        w_state_nxt   = S_CALC;
                    end else if (w_num) begin
                        {w_cnt2_nxt, w_num2_nxt} = enter_digit(r_num2, r_cnt2, num_val);
                    end
                end
                S_CALC: begin
                    // r_tcnt == 0 marks the alu_start cycle; done is not accepted then.
                    if ((r_tcnt != '0) && alu_done) begin
                        if (alu_err) begin
                            w_num1_nxt  = '0;
                            w_state_nxt = S_ERR;
                        end else begin
                            w_num1_nxt = alu_result;
                            if (r_pend_eq) begin
                                w_state_nxt = S_SHOW;
                            end else begin
                                w_op_nxt    = r_pend_op;
                                w_num2_nxt  = '0;
                                w_cnt2_nxt  = '0;
                                w_state_nxt = S_OP;
                            end
                        end
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        w_num1_nxt  = '0;
                        w_state_nxt = S_ERR;
                    end else begin
                        w_tcnt_nxt = r_tcnt + TW'(1);
                    end
                end
                S_SHOW: begin
                    if (is_eq) begin
                        w_pend_eq_nxt = 1'b1;
                        w_state_nxt   = S_CALC;
                    end else if (is_op) begin
                        w_op_nxt    = op_val;
                        w_num2_nxt  = '0;
                        w_cnt2_nxt  = '0;
                        w_state_nxt = S_OP;
                    end else if (w_num) begin
                        {w_cnt1_nxt, w_num1_nxt} = enter_digit('0, '0, num_val);
                        w_num2_nxt  = '0;
                        w_cnt2_nxt  = '0;
                        w_state_nxt = S_N1;
                    end
                end
                S_ERR: begin
                    w_num1_nxt = '0;
                end
                default: begin
                    w_state_nxt   = S_N1;
                    w_num1_nxt    = '0;
                    w_num2_nxt    = '0;
                    w_cnt1_nxt    = '0;
                    w_cnt2_nxt    = '0;
                    w_op_nxt      = '0;
                    w_pend_op_nxt = '0;
                    w_pend_eq_nxt = 1'b0;
                end
            endcase
        end
    end

    assign num1_bcd     = r_num1;
    assign num2_bcd     = r_num2;
    assign operation    = r_op;
    assign alu_start    = (r_state == S_CALC) && (r_tcnt == '0);
    assign result_valid = (r_state == S_SHOW);
    assign error        = (r_state == S_ERR);
    assign curr_state   = r_state;

endmodule
